// File: rtl/e3_display_scanner_if.sv
// Bus between the number source and the display scanner: load/number/blanking
// inputs toward the scanner and the registered display pin outputs back.
interface e3_display_scanner_if #(
    parameter int N_DIGITS = 4
);
    logic                    ld;
    logic [4*N_DIGITS-1:0]   E3_number;
    logic                    blank_lz;
    logic [N_DIGITS-1:0]     digit_sel;
    logic [7:0]              seg;
    logic                    frame_done;
    logic                    err;

    // Number source side.
    modport master (
        output ld, E3_number, blank_lz,
        input  digit_sel, seg, frame_done, err
    );

    // Scanner side.
    modport slave (
        input  ld, E3_number, blank_lz,
        output digit_sel, seg, frame_done, err
    );
endinterface

// File: rtl/e3_display_scanner.sv
// Time-multiplexed scan controller for an N-digit 7-segment display fed with
// Excess-3 coded numbers. A shadow register takes loads at any time; the
// active register only changes at the frame wrap, so a frame never tears.
module e3_display_scanner #(
    parameter int N_DIGITS = 4,
    parameter int PRESC    = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    e3_display_scanner_if.slave  bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int NUM_W = 4 * N_DIGITS;
    localparam logic [NUM_W-1:0] E3_ZERO = {N_DIGITS{4'h3}};

    // Shared E3 digit to segment decoder, {dp,g,f,e,d,c,b,a}; invalid -> dash.
    function automatic logic [7:0] e3_to_seg(input logic [3:0] d);
        case (d)
            4'h3:    e3_to_seg = 8'h3F;
            4'h4:    e3_to_seg = 8'h06;
            4'h5:    e3_to_seg = 8'h5B;
            4'h6:    e3_to_seg = 8'h4F;
            4'h7:    e3_to_seg = 8'h66;
            4'h8:    e3_to_seg = 8'h6D;
            4'h9:    e3_to_seg = 8'h7D;
            4'hA:    e3_to_seg = 8'h07;
            4'hB:    e3_to_seg = 8'h7F;
            4'hC:    e3_to_seg = 8'h6F;
            default: e3_to_seg = 8'h40;
        endcase
    endfunction

    // True when any digit of the number lies outside the E3 range 3..C.
    function automatic logic has_invalid(input logic [NUM_W-1:0] num);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (num[4*k +: 4] < 4'h3 || num[4*k +: 4] > 4'hC) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    logic [CNT_W-1:0]    presc_cnt_q, presc_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_W-1:0]    shadow_q, shadow_d;
    logic [NUM_W-1:0]    active_q, active_d;
    logic                pending_q, pending_d;
    logic [N_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          cur_digit;
    logic                lz_here;
    logic                zero_above;
    logic [N_DIGITS-1:0] upper_zero;

    assign tick = (presc_cnt_q == CNT_W'(PRESC - 1));
    assign wrap = tick && (idx_q == IDX_W'(N_DIGITS - 1));

    // Select the current digit and decide whether it is a blankable leading zero.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cur_digit  = 4'h3;
        lz_here    = 1'b0;
        zero_above = 1'b1;
        upper_zero = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above    = zero_above && (active_q[4*k +: 4] == 4'h3);
            upper_zero[k] = zero_above;
        end
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit = active_q[4*k +: 4];
                lz_here   = upper_zero[k] && (k != 0);
            end
        end
    end

    // Next-state logic: prescaler, digit index, tear-free load and output stage.
    always_comb begin
        presc_cnt_d  = tick ? '0 : presc_cnt_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        err_d        = err_q;
        frame_done_d = wrap;

        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        // The wrap consumes the shadow as it was before this edge; a load on
        // the same edge stays pending for the next frame.
        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            err_d     = has_invalid(shadow_q);
        end
        if (bus.ld) begin
            shadow_d  = bus.E3_number;
            pending_d = 1'b1;
        end

        digit_sel_d = N_DIGITS'(1) << idx_q;
        seg_d       = (bus.blank_lz && lz_here) ? 8'h00 : e3_to_seg(cur_digit);
    end

    // State and registered display outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            presc_cnt_q  <= '0;
            idx_q        <= '0;
            // NOTE: the number registers are reset to E3 zero, not all-zeros,
            // so the display shows 0 and err stays clear after reset.
            shadow_q     <= E3_ZERO;
            active_q     <= E3_ZERO;
            pending_q    <= 1'b0;
            digit_sel_q  <= '0;
            seg_q        <= 8'h00;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            presc_cnt_q  <= presc_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            digit_sel_q  <= digit_sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.digit_sel  = digit_sel_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_e3_display_scanner.sv
// Directed bench for e3_display_scanner: scans whole frames slot by slot
// against hand-decoded segment patterns, plus a PRESC=1 instance.
module tb_e3_display_scanner;

    logic clk = 1'b0;
    logic rst_b;
    logic rst_fast_b;

    always #5 clk = ~clk;

    e3_display_scanner_if #(.N_DIGITS(4)) bus ();
    e3_display_scanner_if #(.N_DIGITS(4)) bus_fast ();

    e3_display_scanner #(.N_DIGITS(4), .PRESC(4)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    e3_display_scanner #(.N_DIGITS(4), .PRESC(1)) u_fast (
        .clk   (clk),
        .rst_b (rst_fast_b),
        .bus   (bus_fast)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one full 16-cycle frame from a frame boundary, checking every cycle.
    // Optional loads are issued on steps a_step and b_step (-1 = none).
    task automatic run_frame(input string tag,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input int a_step, input logic [15:0] a_val,
                             input int b_step, input logic [15:0] b_val);
        logic [7:0] segs [4];
        logic [3:0] sel_exp;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int s = 0; s < 16; s++) begin
            if (s == a_step) begin
                bus.ld        = 1'b1;
                bus.E3_number = a_val;
            end else if (s == b_step) begin
                bus.ld        = 1'b1;
                bus.E3_number = b_val;
            end else begin
                bus.ld = 1'b0;
            end
            step();
            sel_exp = 4'b0001 << (s / 4);
            check($sformatf("%s s%0d sel", tag, s), 32'(bus.digit_sel), 32'(sel_exp));
            check($sformatf("%s s%0d seg", tag, s), 32'(bus.seg), 32'(segs[s / 4]));
            check($sformatf("%s s%0d fd", tag, s), 32'(bus.frame_done), 32'(s == 15));
        end
        bus.ld = 1'b0;
    endtask

    initial begin
        rst_b             = 1'b0;
        rst_fast_b        = 1'b0;
        bus.ld            = 1'b0;
        bus.E3_number     = 16'h3333;
        bus.blank_lz      = 1'b0;
        bus_fast.ld       = 1'b0;
        bus_fast.E3_number = 16'h3333;
        bus_fast.blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        check("rst sel", 32'(bus.digit_sel), 32'h0);
        check("rst seg", 32'(bus.seg), 32'h0);
        check("rst fd", 32'(bus.frame_done), 32'h0);
        check("rst err", 32'(bus.err), 32'h0);

        rst_b = 1'b1;
        run_frame("f1_idle", 8'h3F, 8'h3F, 8'h3F, 8'h3F, -1, 16'h0, -1, 16'h0);

        // Load 1930; the current frame still shows 0000.
        run_frame("f2_ld", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h4C63, -1, 16'h0);
        check("f2 err", 32'(bus.err), 32'h0);

        // 1930 displayed; queue 14 with leading-zero blanking.
        bus.blank_lz = 1'b1;
        run_frame("f3_1930", 8'h3F, 8'h4F, 8'h6F, 8'h06, 0, 16'h3347, -1, 16'h0);
        check("f3 err", 32'(bus.err), 32'h0);
        run_frame("f4_14lz", 8'h66, 8'h06, 8'h00, 8'h00, 0, 16'h3333, -1, 16'h0);

        // Zero with blanking shows only digit 0; queue an invalid digit.
        run_frame("f5_0lz", 8'h3F, 8'h00, 8'h00, 8'h00, 0, 16'h3F35, -1, 16'h0);
        check("f5 err set", 32'(bus.err), 32'h1);

        bus.blank_lz = 1'b0;
        run_frame("f6_bad", 8'h5B, 8'h3F, 8'h40, 8'h3F, 0, 16'h3333, -1, 16'h0);
        check("f6 err clr", 32'(bus.err), 32'h0);

        // Load early in the frame, then again on the wrap tick itself.
        run_frame("f7_wrapld", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h4444, 15, 16'h5555);
        run_frame("f8_old", 8'h06, 8'h06, 8'h06, 8'h06, -1, 16'h0, -1, 16'h0);

        // Back-to-back loads: the later value wins.
        run_frame("f9_5555", 8'h5B, 8'h5B, 8'h5B, 8'h5B, 4, 16'h9999, 5, 16'h3A3B);
        run_frame("f10_last", 8'h7F, 8'h3F, 8'h07, 8'h3F, -1, 16'h0, -1, 16'h0);

        // Mid-slot reset with a pending load that must be discarded.
        for (int s = 0; s < 6; s++) begin
            bus.ld        = (s == 1);
            bus.E3_number = 16'h5555;
            step();
        end
        bus.ld = 1'b0;
        check("pre-rst sel", 32'(bus.digit_sel), 32'h2);
        check("pre-rst seg", 32'(bus.seg), 32'h3F);
        #2;
        rst_b = 1'b0;
        #1;
        check("async sel", 32'(bus.digit_sel), 32'h0);
        check("async seg", 32'(bus.seg), 32'h0);
        check("async fd", 32'(bus.frame_done), 32'h0);
        check("async err", 32'(bus.err), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        run_frame("r1", 8'h3F, 8'h3F, 8'h3F, 8'h3F, -1, 16'h0, -1, 16'h0);
        run_frame("r2", 8'h3F, 8'h3F, 8'h3F, 8'h3F, -1, 16'h0, -1, 16'h0);

        // PRESC=1: the digit advances every cycle.
        rst_fast_b = 1'b1;
        for (int s = 0; s < 8; s++) begin
            logic [3:0] sel_exp;
            step();
            sel_exp = 4'b0001 << (s % 4);
            check($sformatf("fast s%0d sel", s), 32'(bus_fast.digit_sel), 32'(sel_exp));
            check($sformatf("fast s%0d seg", s), 32'(bus_fast.seg), 32'h3F);
            check($sformatf("fast s%0d fd", s), 32'(bus_fast.frame_done), 32'((s % 4) == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
